// File: rtl/l1_coherence_bus_ctrl.sv
// -----------------------------------------------------------------------------
// l1_coherence_bus_ctrl
//
// Shared bus and main-memory controller sitting below two snooping L1 caches.
// Miss and invalidate requests from both cores are arbitrated round-robin.
// Each granted request is snooped in the opposite cache. The reply is either
// the snooped line or main-memory data. Both caches' write-backs are absorbed
// into a FIFO that drains one entry per cycle into the internal RAM.
//
// Ports (lane i = core 0/1, packed as [i*W +: W]):
//   clk, resetn                  clock (rising edge), async active-low reset
//   req_valid/type/addr   in     per-core request, held until req_done
//   req_done, req_rdata   out    one-cycle completion pulse and line data
//   snoop_req/addr        out    snoop to cache i (2'b11 = idle)
//   snoop_found/data      in     cache i supplies the snooped line
//   cpu_wb*, bus_wb*      in     write-back strobes/addresses/data per cache
//   wb_overflow           out    sticky: a write-back was dropped (FIFO full)
// -----------------------------------------------------------------------------
module l1_coherence_bus_ctrl #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 2,
  parameter int WB_DEPTH = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          req_valid,
  input  logic [3:0]          req_type,
  input  logic [2*ADDR_W-1:0] req_addr,
  output logic [1:0]          req_done,
  output logic [2*DATA_W-1:0] req_rdata,
  output logic [3:0]          snoop_req,
  output logic [2*ADDR_W-1:0] snoop_addr,
  input  logic [1:0]          snoop_found,
  input  logic [2*DATA_W-1:0] snoop_data,
  input  logic [1:0]          cpu_wb,
  input  logic [2*ADDR_W-1:0] cpu_wb_addr,
  input  logic [2*DATA_W-1:0] cpu_wb_data,
  input  logic [1:0]          bus_wb,
  input  logic [2*ADDR_W-1:0] bus_wb_addr,
  input  logic [2*DATA_W-1:0] bus_wb_data,
  output logic                wb_overflow
);

  localparam int PW    = $clog2(WB_DEPTH);   // FIFO pointer width
  localparam int CW    = PW + 1;             // occupancy 0..WB_DEPTH
  localparam int NW    = (CW > 3) ? CW : 3;  // holds up to 4 pushes and free space
  localparam int LAT_W = 3;

  localparam logic [1:0] T_INV  = 2'b00;
  localparam logic [1:0] T_RSVD = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_SNOOP, ST_MEM, ST_RESP} state_e;

  state_e              r_state, w_next_state;
  logic                r_core;
  logic [1:0]          r_type;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rr;
  logic [DATA_W-1:0]   r_result;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic                r_overflow;

  logic [DATA_W-1:0]   r_mem     [2**ADDR_W];
  logic [ADDR_W-1:0]   r_wb_addr [WB_DEPTH];
  logic [DATA_W-1:0]   r_wb_data [WB_DEPTH];
  logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]       r_count;

  logic [1:0]          w_legal;
  logic                w_grant;
  logic                w_other_found;
  logic [DATA_W-1:0]   w_other_data;
  logic [DATA_W-1:0]   w_ram_rdata;
  logic                w_buf_hit;
  logic [DATA_W-1:0]   w_buf_data;
  logic [PW-1:0]       w_srch_idx;

  logic                w_pop;
  logic [NW-1:0]       w_free;
  logic [NW-1:0]       w_n_push;
  logic                w_drop;
  logic [3:0]          w_push_req;
  logic [3:0]          w_push_ok;
  logic [PW-1:0]       w_push_slot [4];
  logic [ADDR_W-1:0]   w_push_addr [4];
  logic [DATA_W-1:0]   w_push_data [4];

  // ---------------------------------------------------------------------------
  // Arbitration: reserved type never competes; on a tie r_rr picks the core.
  // ---------------------------------------------------------------------------
  assign w_legal[0] = req_valid[0] && (req_type[1:0] != T_RSVD);
  assign w_legal[1] = req_valid[1] && (req_type[3:2] != T_RSVD);
  assign w_grant    = (w_legal == 2'b11) ? r_rr : ~w_legal[0];

  // The snoop always targets the core that was not granted.
  assign w_other_found = r_core ? snoop_found[0] : snoop_found[1];
  assign w_other_data  = r_core ? snoop_data[DATA_W-1:0] : snoop_data[2*DATA_W-1:DATA_W];
  assign w_ram_rdata   = r_mem[r_addr];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge value of every other register, independent of block order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // FSM: next-state logic
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (|w_legal) w_next_state = ST_SNOOP;
      ST_SNOOP: w_next_state = (r_type == T_INV || w_other_found) ? ST_RESP : ST_MEM;
      ST_MEM:   if (r_lat_cnt == LAT_W'(MEM_LAT - 1)) w_next_state = ST_RESP;
      ST_RESP:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // FSM: outputs, decoded from the registered state only
  always_comb begin
    req_done   = '0;
    req_rdata  = '0;
    snoop_req  = 4'b1111;
    snoop_addr = '0;
    unique case (r_state)
      ST_SNOOP: begin
        if (r_core) begin
          snoop_req[1:0]          = r_type;
          snoop_addr[ADDR_W-1:0]  = r_addr;
        end else begin
          snoop_req[3:2]                 = r_type;
          snoop_addr[2*ADDR_W-1:ADDR_W]  = r_addr;
        end
      end
      ST_RESP: begin
        if (r_core) begin
          req_done[1]                    = 1'b1;
          req_rdata[2*DATA_W-1:DATA_W]   = r_result;
        end else begin
          req_done[0]                    = 1'b1;
          req_rdata[DATA_W-1:0]          = r_result;
        end
      end
      default: ;
    endcase
  end

  assign wb_overflow = r_overflow;

  // ---------------------------------------------------------------------------
  // Request datapath: grant latch, snoop capture, memory result, rr pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_core    <= 1'b0;
      r_type    <= T_RSVD;
      r_addr    <= '0;
      r_rr      <= 1'b0;
      r_result  <= '0;
      r_lat_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (|w_legal) begin
            r_core <= w_grant;
            r_type <= w_grant ? req_type[3:2] : req_type[1:0];
            r_addr <= w_grant ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          end
        end
        ST_SNOOP: begin
          r_lat_cnt <= '0;
          if (r_type == T_INV)    r_result <= '0;
          else if (w_other_found) r_result <= w_other_data;
        end
        ST_MEM: begin
          // Lookup happens in the first MEM cycle so write-backs pushed during
          // SNOOP are already in the buffer. An entry draining this same cycle
          // is still found in the buffer, covering the stale RAM read.
          if (r_lat_cnt == '0) r_result <= w_buf_hit ? w_buf_data : w_ram_rdata;
          r_lat_cnt <= r_lat_cnt + 1'b1;
        end
        ST_RESP: r_rr <= ~r_core;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back buffer search: walk oldest to newest so the newest match wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_buf_hit  = 1'b0;
    w_buf_data = '0;
    w_srch_idx = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      w_srch_idx = r_rd_ptr + PW'(k);
      if ((CW'(k) < r_count) && (r_wb_addr[w_srch_idx] == r_addr)) begin
        w_buf_hit  = 1'b1;
        w_buf_data = r_wb_data[w_srch_idx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back buffer push/pop. Push order: c0 cpu, c0 bus, c1 cpu, c1 bus.
  // The pop of this cycle frees a slot before pushes are admitted.
  // ---------------------------------------------------------------------------
  assign w_push_req     = {bus_wb[1], cpu_wb[1], bus_wb[0], cpu_wb[0]};
  assign w_push_addr[0] = cpu_wb_addr[ADDR_W-1:0];
  assign w_push_addr[1] = bus_wb_addr[ADDR_W-1:0];
  assign w_push_addr[2] = cpu_wb_addr[2*ADDR_W-1:ADDR_W];
  assign w_push_addr[3] = bus_wb_addr[2*ADDR_W-1:ADDR_W];
  assign w_push_data[0] = cpu_wb_data[DATA_W-1:0];
  assign w_push_data[1] = bus_wb_data[DATA_W-1:0];
  assign w_push_data[2] = cpu_wb_data[2*DATA_W-1:DATA_W];
  assign w_push_data[3] = bus_wb_data[2*DATA_W-1:DATA_W];

  assign w_pop  = (r_count != '0);
  assign w_free = NW'(WB_DEPTH) - NW'(r_count) + NW'(w_pop);

  always_comb begin
    w_n_push  = '0;
    w_drop    = 1'b0;
    w_push_ok = '0;
    for (int j = 0; j < 4; j++) begin
      w_push_slot[j] = '0;
      if (w_push_req[j]) begin
        if (w_n_push < w_free) begin
          w_push_ok[j]   = 1'b1;
          w_push_slot[j] = r_wr_ptr + w_n_push[PW-1:0];
          w_n_push       = w_n_push + 1'b1;
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_n_push[PW-1:0];
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= r_count - CW'(w_pop) + CW'(w_n_push);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // NOTE: storage arrays are deliberately not reset; validity is tracked by the
  // reset pointers/count, and leaving them unreset lets them map onto RAM.
  always_ff @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (w_push_ok[j]) begin
        r_wb_addr[w_push_slot[j]] <= w_push_addr[j];
        r_wb_data[w_push_slot[j]] <= w_push_data[j];
      end
    end
  end

  // Drain port: independent of the request FSM.
  always_ff @(posedge clk) begin
    if (w_pop) r_mem[r_wb_addr[r_rd_ptr]] <= r_wb_data[r_rd_ptr];
  end

endmodule

// File: tb/tb_l1_coherence_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_l1_coherence_bus_ctrl
//
// Directed bench for l1_coherence_bus_ctrl with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling
// edge (or 1 ns after a rising edge). Latencies are counted in cycles from the
// IDLE cycle in which a request is first seen (offset 0).
// -----------------------------------------------------------------------------
module tb_l1_coherence_bus_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req_valid;
  logic [3:0]  req_type;
  logic [17:0] req_addr;
  logic [1:0]  req_done;
  logic [63:0] req_rdata;
  logic [3:0]  snoop_req;
  logic [17:0] snoop_addr;
  logic [1:0]  snoop_found;
  logic [63:0] snoop_data;
  logic [1:0]  cpu_wb, bus_wb;
  logic [17:0] cpu_wb_addr, bus_wb_addr;
  logic [63:0] cpu_wb_data, bus_wb_data;
  logic        wb_overflow;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  l1_coherence_bus_ctrl #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(2), .WB_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr),
    .req_done(req_done), .req_rdata(req_rdata),
    .snoop_req(snoop_req), .snoop_addr(snoop_addr),
    .snoop_found(snoop_found), .snoop_data(snoop_data),
    .cpu_wb(cpu_wb), .cpu_wb_addr(cpu_wb_addr), .cpu_wb_data(cpu_wb_data),
    .bus_wb(bus_wb), .bus_wb_addr(bus_wb_addr), .bus_wb_data(bus_wb_data),
    .wb_overflow(wb_overflow)
  );

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // ---------------------------------------------------------------------------
  task automatic start_req(input bit core, input logic [1:0] t, input logic [8:0] a);
    if (core) begin req_type[3:2] = t; req_addr[17:9] = a; end
    else      begin req_type[1:0] = t; req_addr[8:0]  = a; end
    req_valid[core] = 1'b1;
  endtask

  task automatic set_snoop(input bit core, input bit found, input logic [31:0] d);
    snoop_found[core] = found;
    if (core) snoop_data[63:32] = d;
    else      snoop_data[31:0]  = d;
  endtask

  // Write one word into RAM through core0's cpu write-back and let it drain.
  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    cpu_wb[0] = 1'b1; cpu_wb_addr[8:0] = a; cpu_wb_data[31:0] = d;
    @(posedge clk); #1;
    cpu_wb = '0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  // Wait for req_done[core]; report offset, data, other lane and snoop state at
  // offset 1. Drops req_valid in the cycle after req_done. lat = -1 on timeout.
  task automatic wait_done(input bit core, output int lat, output logic [31:0] data,
                           output logic [31:0] other, output logic [3:0] snp,
                           output logic [17:0] snp_addr);
    lat = -1; data = '0; other = '0; snp = 4'hF; snp_addr = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 1) begin snp = snoop_req; snp_addr = snoop_addr; end
      if (req_done[core]) begin
        lat   = c;
        data  = core ? req_rdata[63:32] : req_rdata[31:0];
        other = core ? req_rdata[31:0]  : req_rdata[63:32];
        break;
      end
      @(posedge clk); #1;
      cpu_wb = '0; bus_wb = '0;
    end
    @(posedge clk); #1;
    req_valid[core] = 1'b0;
    cpu_wb = '0; bus_wb = '0;
    snoop_found = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    for (int p = 0; p < 2; p++) begin
      if (p == 1) begin
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
      end
      n_total++; if (req_done !== 2'b00) begin n_bad++; $display("FAIL reset_done p%0d got=%b exp=00", p, req_done); end
      n_total++; if (req_rdata !== 64'h0) begin n_bad++; $display("FAIL reset_rdata p%0d got=%h exp=0", p, req_rdata); end
      n_total++; if (snoop_req !== 4'b1111) begin n_bad++; $display("FAIL reset_snoop_req p%0d got=%b exp=1111", p, snoop_req); end
      n_total++; if (snoop_addr !== 18'h0) begin n_bad++; $display("FAIL reset_snoop_addr p%0d got=%h exp=0", p, snoop_addr); end
      n_total++; if (wb_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow p%0d got=%b exp=0", p, wb_overflow); end
    end
  endtask

  task automatic test_arbitration();
    int lat0, lat1;
    logic [31:0] d0, d1;
    lat0 = -1; lat1 = -1; d0 = '0; d1 = '0;
    set_snoop(1'b1, 1'b1, 32'hAAAA0001);  // core1 cache supplies core0's line
    set_snoop(1'b0, 1'b1, 32'hBBBB0002);  // core0 cache supplies core1's line
    start_req(1'b0, 2'b01, 9'h0A0);
    start_req(1'b1, 2'b10, 9'h0B0);
    for (int c = 0; c < 20 && lat1 < 0; c++) begin
      @(negedge clk);
      if (req_done[0] && lat0 < 0) begin lat0 = c; d0 = req_rdata[31:0]; end
      if (req_done[1] && lat1 < 0) begin lat1 = c; d1 = req_rdata[63:32]; end
      @(posedge clk); #1;
      if (lat0 >= 0) req_valid[0] = 1'b0;
      if (lat1 >= 0) req_valid[1] = 1'b0;
    end
    req_valid = '0; snoop_found = '0;
    n_total++; if (lat0 !== 2) begin n_bad++; $display("FAIL arb_core0_lat got=%0d exp=2", lat0); end
    n_total++; if (d0 !== 32'hAAAA0001) begin n_bad++; $display("FAIL arb_core0_data got=%h exp=aaaa0001", d0); end
    n_total++; if (lat1 !== 5) begin n_bad++; $display("FAIL arb_core1_lat got=%0d exp=5", lat1); end
    n_total++; if (d1 !== 32'hBBBB0002) begin n_bad++; $display("FAIL arb_core1_data got=%h exp=bbbb0002", d1); end
  endtask

  task automatic test_read_miss_mem();
    int lat; logic [31:0] d, o; logic [3:0] s; logic [17:0] sa;
    set_snoop(1'b1, 1'b0, 32'h0);
    start_req(1'b0, 2'b10, 9'h012);
    wait_done(1'b0, lat, d, o, s, sa);
    n_total++; if (s !== 4'b1011) begin n_bad++; $display("FAIL rd_snoop_req got=%b exp=1011", s); end
    n_total++; if (sa !== {9'h012, 9'h000}) begin n_bad++; $display("FAIL rd_snoop_addr got=%h exp=%h", sa, {9'h012, 9'h000}); end
    n_total++; if (lat !== 4) begin n_bad++; $display("FAIL rd_lat got=%0d exp=4", lat); end
    n_total++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data got=%h exp=deadbeef", d); end
    n_total++; if (o !== 32'h0) begin n_bad++; $display("FAIL rd_other_lane got=%h exp=0", o); end
  endtask

  task automatic test_write_miss_found();
    int lat; logic [31:0] d, o; logic [3:0] s; logic [17:0] sa;
    set_snoop(1'b0, 1'b1, 32'hCAFEF00D);
    start_req(1'b1, 2'b01, 9'h1FF);
    wait_done(1'b1, lat, d, o, s, sa);
    n_total++; if (s !== 4'b1101) begin n_bad++; $display("FAIL wm_snoop_req got=%b exp=1101", s); end
    n_total++; if (sa !== {9'h000, 9'h1FF}) begin n_bad++; $display("FAIL wm_snoop_addr got=%h exp=%h", sa, {9'h000, 9'h1FF}); end
    n_total++; if (lat !== 2) begin n_bad++; $display("FAIL wm_lat got=%0d exp=2", lat); end
    n_total++; if (d !== 32'hCAFEF00D) begin n_bad++; $display("FAIL wm_data got=%h exp=cafef00d", d); end
  endtask

  task automatic test_invalidate();
    int lat; logic [31:0] d, o; logic [3:0] s; logic [17:0] sa;
    set_snoop(1'b1, 1'b1, 32'h12345678);
    start_req(1'b0, 2'b00, 9'h020);
    wait_done(1'b0, lat, d, o, s, sa);
    n_total++; if (s !== 4'b0011) begin n_bad++; $display("FAIL inv_snoop_req got=%b exp=0011", s); end
    n_total++; if (lat !== 2) begin n_bad++; $display("FAIL inv_lat got=%0d exp=2", lat); end
    n_total++; if (d !== 32'h0) begin n_bad++; $display("FAIL inv_data got=%h exp=0", d); end
  endtask

  task automatic test_reserved();
    int n_done, n_snoop;
    n_done = 0; n_snoop = 0;
    start_req(1'b1, 2'b11, 9'h033);
    repeat (8) begin
      @(negedge clk);
      if (req_done !== 2'b00) n_done++;
      if (snoop_req !== 4'b1111) n_snoop++;
    end
    @(posedge clk); #1;
    req_valid = '0;
    n_total++; if (n_done !== 0) begin n_bad++; $display("FAIL rsvd_done got=%0d exp=0", n_done); end
    n_total++; if (n_snoop !== 0) begin n_bad++; $display("FAIL rsvd_snoop got=%0d exp=0", n_snoop); end
  endtask

  task automatic test_wb_forward();
    int lat; logic [31:0] d, o; logic [3:0] s; logic [17:0] sa;
    cpu_wb[0] = 1'b1; cpu_wb_addr[8:0] = 9'h040; cpu_wb_data[31:0] = 32'h11111111;
    @(posedge clk); #1;
    cpu_wb = '0;
    set_snoop(1'b0, 1'b0, 32'h0);
    start_req(1'b1, 2'b10, 9'h040);
    wait_done(1'b1, lat, d, o, s, sa);
    n_total++; if (lat !== 4) begin n_bad++; $display("FAIL fwd_lat got=%0d exp=4", lat); end
    n_total++; if (d !== 32'h11111111) begin n_bad++; $display("FAIL fwd_data got=%h exp=11111111", d); end
    repeat (4) @(posedge clk);
    #1;
    start_req(1'b0, 2'b10, 9'h040);
    wait_done(1'b0, lat, d, o, s, sa);
    n_total++; if (d !== 32'h11111111) begin n_bad++; $display("FAIL fwd_ram_data got=%h exp=11111111", d); end
  endtask

  // Backlog keeps two writes to 0x050 in the buffer at lookup; newest must win.
  task automatic test_wb_newest();
    int lat; logic [31:0] d, o; logic [3:0] s; logic [17:0] sa;
    cpu_wb = 2'b11; bus_wb = 2'b11;
    cpu_wb_addr = {9'h102, 9'h100}; bus_wb_addr = {9'h050, 9'h101};
    cpu_wb_data = {32'h00000102, 32'h00000100}; bus_wb_data = {32'h12121212, 32'h00000101};
    @(posedge clk); #1;
    cpu_wb_addr = {9'h106, 9'h104}; bus_wb_addr = {9'h050, 9'h105};
    cpu_wb_data = {32'h00000106, 32'h00000104}; bus_wb_data = {32'h5555AAAA, 32'h00000105};
    set_snoop(1'b1, 1'b0, 32'h0);
    start_req(1'b0, 2'b10, 9'h050);
    wait_done(1'b0, lat, d, o, s, sa);
    n_total++; if (lat !== 4) begin n_bad++; $display("FAIL newest_lat got=%0d exp=4", lat); end
    n_total++; if (d !== 32'h5555AAAA) begin n_bad++; $display("FAIL newest_data got=%h exp=5555aaaa", d); end
    repeat (12) @(posedge clk);
    #1;
    start_req(1'b1, 2'b10, 9'h050);
    wait_done(1'b1, lat, d, o, s, sa);
    n_total++; if (d !== 32'h5555AAAA) begin n_bad++; $display("FAIL newest_ram_data got=%h exp=5555aaaa", d); end
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] d, o; logic [3:0] s; logic [17:0] sa;
    logic [8:0] b;
    preload(9'h0CB, 32'hABCDEF01);
    for (int k = 0; k < 3; k++) begin
      b = 9'h0C0 + 9'(4 * k);
      cpu_wb = 2'b11; bus_wb = 2'b11;
      cpu_wb_addr = {b + 9'd2, b};         bus_wb_addr = {b + 9'd3, b + 9'd1};
      cpu_wb_data = {23'h0, b + 9'd2, 23'h0, b};
      bus_wb_data = {23'h0, b + 9'd3, 23'h0, b + 9'd1};
      cpu_wb_data[63:60] = 4'h1; cpu_wb_data[31:28] = 4'h1;
      bus_wb_data[63:60] = 4'h1; bus_wb_data[31:28] = 4'h1;
      @(posedge clk); #1;
      n_total++;
      if (wb_overflow !== (k == 2)) begin
        n_bad++; $display("FAIL ovf_cycle%0d got=%b exp=%b", k + 1, wb_overflow, (k == 2));
      end
    end
    cpu_wb = '0; bus_wb = '0;
    repeat (20) @(posedge clk);
    #1;
    n_total++; if (wb_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b exp=1", wb_overflow); end
    set_snoop(1'b1, 1'b0, 32'h0);
    start_req(1'b0, 2'b10, 9'h0CB);
    wait_done(1'b0, lat, d, o, s, sa);
    n_total++; if (d !== 32'hABCDEF01) begin n_bad++; $display("FAIL ovf_dropped_data got=%h exp=abcdef01", d); end
    start_req(1'b0, 2'b10, 9'h0C9);
    wait_done(1'b0, lat, d, o, s, sa);
    n_total++; if (d !== 32'h100000C9) begin n_bad++; $display("FAIL ovf_kept_data got=%h exp=100000c9", d); end
    start_req(1'b0, 2'b10, 9'h0C3);
    wait_done(1'b0, lat, d, o, s, sa);
    n_total++; if (d !== 32'h100000C3) begin n_bad++; $display("FAIL ovf_early_data got=%h exp=100000c3", d); end
  endtask

  task automatic test_reset_mid();
    int lat, n_done; logic [31:0] d, o; logic [3:0] s; logic [17:0] sa;
    n_done = 0;
    set_snoop(1'b1, 1'b0, 32'h0);
    start_req(1'b0, 2'b10, 9'h012);
    repeat (3) @(negedge clk);           // offset 2: first MEM cycle
    resetn = 1'b0;
    #1;
    n_total++; if (wb_overflow !== 1'b0) begin n_bad++; $display("FAIL rstmid_overflow got=%b exp=0", wb_overflow); end
    n_total++; if (snoop_req !== 4'b1111) begin n_bad++; $display("FAIL rstmid_snoop_req got=%b exp=1111", snoop_req); end
    req_valid = '0;
    @(posedge clk); #1;
    n_total++; if (req_done !== 2'b00) begin n_bad++; $display("FAIL rstmid_done got=%b exp=00", req_done); end
    n_total++; if (req_rdata !== 64'h0) begin n_bad++; $display("FAIL rstmid_rdata got=%h exp=0", req_rdata); end
    @(negedge clk); resetn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (req_done !== 2'b00) n_done++;
    end
    n_total++; if (n_done !== 0) begin n_bad++; $display("FAIL rstmid_stray_done got=%0d exp=0", n_done); end
    @(posedge clk); #1;
    start_req(1'b0, 2'b10, 9'h012);
    wait_done(1'b0, lat, d, o, s, sa);
    n_total++; if (lat !== 4) begin n_bad++; $display("FAIL rstmid_reissue_lat got=%0d exp=4", lat); end
    n_total++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rstmid_reissue_data got=%h exp=deadbeef", d); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    resetn = 1'b0;
    req_valid = '0; req_type = 4'hF; req_addr = '0;
    snoop_found = '0; snoop_data = '0;
    cpu_wb = '0; cpu_wb_addr = '0; cpu_wb_data = '0;
    bus_wb = '0; bus_wb_addr = '0; bus_wb_data = '0;
    #8;
    test_reset();
    test_arbitration();
    preload(9'h012, 32'hDEADBEEF);
    test_read_miss_mem();
    test_write_miss_found();
    test_invalidate();
    test_reserved();
    test_wb_forward();
    test_wb_newest();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule

// File: doc/l1_coherence_bus_ctrl.md
# l1_coherence_bus_ctrl

Shared bus and main-memory controller downstream of the two per-core L1 wrappers (picorv32 + directly-mapped snooping cache). It arbitrates miss and invalidate requests from both caches, forwards each request as a snoop to the opposite cache, and returns either the cache-supplied line or main-memory data. It also absorbs both caches' write-backs (cpu and bus) into a write-back buffer that drains into the internal main-memory array.

## Interface
Parameters:
- ADDR_W, 9, word address width; memory depth is 2^ADDR_W words
- DATA_W, 32, data word width
- MEM_LAT, 2, main-memory read latency in cycles; legal range 1..7
- WB_DEPTH, 8, write-back buffer entries; power of two

Ports (index i = core 0/1, packed as [i*W +: W]):
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  2  core i has a pending request; held until req_done[i]
- req_type  in  4  per core: 00 invalidate, 01 write miss, 10 read miss, 11 reserved (ignored)
- req_addr  in  2*ADDR_W  request word address
- req_done  out  2  one-cycle completion pulse to core i
- req_rdata  out  2*DATA_W  line data, valid with req_done for read/write miss
- snoop_req  out  4  bus request to cache i; 11 = idle, otherwise same encoding as req_type
- snoop_addr  out  2*ADDR_W  snooped address
- snoop_found  in  2  cache i holds the snooped line and aborts the memory access
- snoop_data  in  2*DATA_W  data from cache i, valid with snoop_found[i]
- cpu_wb, bus_wb  in  2 each  write-back strobes from cache i
- cpu_wb_addr, bus_wb_addr  in  2*ADDR_W each  write-back addresses
- cpu_wb_data, bus_wb_data  in  2*DATA_W each  write-back data
- wb_overflow  out  1  sticky: a write-back was dropped because the buffer was full

## Operation
- FSM states: IDLE, SNOOP, MEM, RESP.
- IDLE: when any req_valid with legal type, grant round-robin; rr pointer favours the core not granted last; on reset favours core 0. Latch core id, type and address; go to SNOOP. Reserved type 11 is never granted.
- SNOOP (1 cycle): drive snoop_req/snoop_addr to the other core only; the granted core's snoop_req stays 11. Sample snoop_found of the other core at end of cycle.
  - Invalidate: go to RESP regardless of found; req_rdata = 0.
  - Miss with found: capture snoop_data; go to RESP.
  - Miss without found: go to MEM.
- MEM: at entry, issue RAM read and search write-back buffer; newest matching entry overrides RAM data. Result held; after MEM_LAT cycles in MEM go to RESP.
- RESP (1 cycle): req_done[core]=1, req_rdata[core]=result; the other lane's req_rdata is 0. Flip rr pointer; return to IDLE.
- Write-back buffer: FIFO, up to 4 pushes per cycle in fixed order core0 cpu, core0 bus, core1 cpu, core1 bus. Each push that finds the FIFO full is dropped and sets wb_overflow. One entry drains per cycle to RAM when non-empty; drain is independent of FSM state (separate write port). Pushes and pop in the same cycle are both allowed; the pop frees space before pushes are counted.
- RAM contents are not reset.

## Timing
- Request seen in IDLE at cycle t: SNOOP at t+1; RESP (req_done) at t+2 for invalidate/found; t+2+MEM_LAT for memory path.
- Core must hold req_valid/addr/type until req_done; it deasserts in the cycle after req_done. A request still high in the RESP cycle is not regranted until IDLE (next cycle).
- Reset values: req_done=0, req_rdata=0, snoop_req=4'b1111, snoop_addr=0, wb_overflow=0, FSM IDLE, FIFO empty, rr to core 0.
- Reset asserted mid-operation: FSM to IDLE immediately, pending grant dropped (no req_done), FIFO flushed, wb_overflow cleared.
- Write-back pushed at cycle t is visible to a MEM-entry search at t+1 onward; it reaches RAM no earlier than t+1.
- Buffer occupancy wraps modulo WB_DEPTH on pointers; full = WB_DEPTH entries.

## Test plan
- Core0 read miss at 0x012, core1 snoop_found=0, RAM[0x012]=0xDEADBEEF -> snoop_req core1=10, addr 0x012 at t+1; req_done[0] with 0xDEADBEEF at t+4 (MEM_LAT=2).
- Core1 write miss 0x1FF, core0 snoop_found=1 data 0xCAFEF00D -> req_done[1] at t+2 with 0xCAFEF00D; no RAM access.
- Both cores request in the same cycle after reset -> core0 served first, core1 granted in the IDLE cycle after core0's RESP.
- Core0 cpu_wb 0x040 data 0x11111111, then core1 read miss 0x040 next cycle, no snoop hit -> req_rdata 0x11111111 via buffer forward; RAM[0x040]=0x11111111 afterwards.
- Four simultaneous write-backs for three consecutive cycles with WB_DEPTH=8 -> drops start in the third cycle (8+ occupancy), wb_overflow=1 and stays 1 until reset.
- resetn low during MEM -> all outputs at reset values next edge; no req_done for the aborted request; re-issued request completes normally.
